// File: rtl/bound_flasher_sequencer_pkg.sv
// Shared definitions for the bound flasher: state encodings, lamp target patterns
// and the mapping from a next state to the lamp register operation.
package bound_flasher_pkg;

   localparam int unsigned LAMP_COUNT = 16;

   typedef enum logic [2:0] {
      ST_INITIAL = 3'd0,
      ST_UP_5    = 3'd1,
      ST_DN_0    = 3'd2,
      ST_UP_10   = 3'd3,
      ST_DN_5    = 3'd4,
      ST_UP_15   = 3'd5,
      ST_DN_ALL  = 3'd6,
      ST_ILLEGAL = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      LS_CLEAR = 2'd0,
      LS_UP    = 2'd1,
      LS_DOWN  = 2'd2
   } lamp_op_e;

   localparam logic [LAMP_COUNT-1:0] LP_5   = 16'h003F;
   localparam logic [LAMP_COUNT-1:0] LP_4   = 16'h001F;
   localparam logic [LAMP_COUNT-1:0] LP_10  = 16'h07FF;
   localparam logic [LAMP_COUNT-1:0] LP_ALL = 16'hFFFF;

   // Lamp motion follows the state being entered, so a target pattern is never overshot.
   function automatic lamp_op_e lamp_op(input state_e st);
      lamp_op_e op;
      case (st)
         ST_UP_5, ST_UP_10, ST_UP_15: op = LS_UP;
         ST_DN_0, ST_DN_5, ST_DN_ALL: op = LS_DOWN;
         default:                     op = LS_CLEAR;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bound_flasher_sequencer_if.sv
// Signals exchanged between the state register side (master) and the sequencer (slave).
interface bound_flasher_sequencer_if;
   import bound_flasher_pkg::*;

   logic                  flick;
   logic [2:0]            cur_st;
   logic [2:0]            nxt_st;
   logic [LAMP_COUNT-1:0] lamps;

   modport master (
      output flick,
      output cur_st,
      input  nxt_st,
      input  lamps
   );

   modport slave (
      input  flick,
      input  cur_st,
      output nxt_st,
      output lamps
   );

endinterface

// File: rtl/bound_flasher_sequencer_lamp_shift_reg.sv
// Lamp register: asynchronous clear, then per-edge clear / fill-up / drain-down.
module lamp_shift_reg
   import bound_flasher_pkg::*;
#(
   parameter int unsigned N_LAMPS = LAMP_COUNT
) (
   input  logic               div_clk,
   input  logic               rst,
   input  lamp_op_e           op,
   output logic [N_LAMPS-1:0] lamps
);

   always_ff @(posedge div_clk or posedge rst) begin
      if (rst) begin
         lamps <= '0;
      end else begin
         case (op)
            LS_UP:   lamps <= {lamps[N_LAMPS-2:0], 1'b1};
            LS_DOWN: lamps <= {1'b0, lamps[N_LAMPS-1:1]};
            default: lamps <= '0;
         endcase
      end
   end

endmodule

// File: rtl/bound_flasher_sequencer.sv
// Next-state decode and lamp output of the bound flasher; the state register lives outside
// and feeds cur_st back in.
module bound_flasher_sequencer
   import bound_flasher_pkg::*;
#(
   parameter int unsigned N_LAMPS = 16
) (
   input logic                      div_clk,
   input logic                      rst,
   bound_flasher_sequencer_if.slave bus
);

   state_e             cur;
   state_e             nxt;
   lamp_op_e           op;
   logic [N_LAMPS-1:0] lamps_q;

   assign cur = state_e'(bus.cur_st);

   always_comb begin
      nxt = ST_INITIAL;
      case (cur)
         ST_INITIAL: nxt = bus.flick ? ST_UP_5 : ST_INITIAL;
         ST_UP_5:    nxt = (lamps_q == LP_5) ? ST_DN_0 : ST_UP_5;
         ST_DN_0:    nxt = (lamps_q == '0) ? ST_UP_10 : ST_DN_0;
         ST_UP_10: begin
            // Kickback takes priority over the normal reversal at lamp 10.
            if (bus.flick && (lamps_q == LP_5 || lamps_q == LP_10))
               nxt = ST_DN_0;
            else if (lamps_q == LP_10)
               nxt = ST_DN_5;
            else
               nxt = ST_UP_10;
         end
         ST_DN_5:    nxt = (lamps_q == LP_4) ? ST_UP_15 : ST_DN_5;
         ST_UP_15: begin
            if (bus.flick && lamps_q == LP_10)
               nxt = ST_DN_5;
            else if (lamps_q == LP_ALL)
               nxt = ST_DN_ALL;
            else
               nxt = ST_UP_15;
         end
         ST_DN_ALL:  nxt = (lamps_q == '0) ? ST_INITIAL : ST_DN_ALL;
         default:    nxt = ST_INITIAL;
      endcase
   end

   assign op         = lamp_op(nxt);
   assign bus.nxt_st = nxt;
   assign bus.lamps  = lamps_q;

   lamp_shift_reg #(
      .N_LAMPS (N_LAMPS)
   ) u_lamps (
      .div_clk (div_clk),
      .rst     (rst),
      .op      (op),
      .lamps   (lamps_q)
   );

endmodule

// File: tb/tb_bound_flasher_sequencer.sv
// Bench for bound_flasher_sequencer; the external state register is modelled by the cycle task.
module tb_bound_flasher_sequencer;
   import bound_flasher_pkg::*;

   typedef struct {
      logic        flick;
      logic [2:0]  exp_st;
      logic [15:0] exp_lamps;
   } vec_t;

   logic div_clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[$];
   logic [15:0] lp;

   bound_flasher_sequencer_if bus ();

   bound_flasher_sequencer #(
      .N_LAMPS (16)
   ) dut (
      .div_clk (div_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 div_clk = ~div_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One div_clk edge; cur_st takes the nxt_st seen just before the edge.
   task automatic cycle(input logic f);
      logic [2:0] ns;
      @(negedge div_clk);
      bus.flick = f;
      #1;
      ns = bus.nxt_st;
      @(posedge div_clk);
      #1;
      bus.cur_st = ns;
   endtask

   task automatic restart();
      rst        = 1'b1;
      bus.flick  = 1'b0;
      bus.cur_st = ST_INITIAL;
      @(negedge div_clk);
      @(negedge div_clk);
      rst = 1'b0;
   endtask

   // Leaves the design just after edge n of a sweep started by a one-cycle flick.
   task automatic go_to(input int n);
      restart();
      cycle(1'b1);
      repeat (n - 1) cycle(1'b0);
   endtask

   task automatic push_seg(input int n, input logic [2:0] st, input logic up);
      for (int i = 0; i < n; i++) begin
         lp = up ? {lp[14:0], 1'b1} : {1'b0, lp[15:1]};
         tbl.push_back('{1'b0, st, lp});
      end
   endtask

   function automatic logic [31:0] st_lamps();
      return {13'b0, bus.cur_st, bus.lamps};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      bus.flick  = 1'b0;
      bus.cur_st = ST_INITIAL;

      lp = 16'h0001;
      tbl.push_back('{1'b1, ST_UP_5, lp});
      push_seg(5,  ST_UP_5,   1'b1);
      push_seg(6,  ST_DN_0,   1'b0);
      push_seg(11, ST_UP_10,  1'b1);
      push_seg(6,  ST_DN_5,   1'b0);
      push_seg(11, ST_UP_15,  1'b1);
      push_seg(16, ST_DN_ALL, 1'b0);
      tbl.push_back('{1'b0, ST_INITIAL, 16'h0000});
      tbl.push_back('{1'b0, ST_INITIAL, 16'h0000});

      #3;
      chk("reset_lamps", {16'b0, bus.lamps}, 32'h0);
      chk("reset_nxt", {29'b0, bus.nxt_st}, {29'b0, ST_INITIAL});
      bus.flick = 1'b1;
      #1;
      chk("init_flick_nxt", {29'b0, bus.nxt_st}, {29'b0, ST_UP_5});
      bus.flick = 1'b0;

      restart();
      foreach (tbl[i]) begin
         cycle(tbl[i].flick);
         chk($sformatf("sweep[%0d]", i), st_lamps(), {13'b0, tbl[i].exp_st, tbl[i].exp_lamps});
      end

      go_to(20);
      chk("rst_pre", st_lamps(), {13'b0, ST_UP_10, 16'h00FF});
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_lamps", {16'b0, bus.lamps}, 32'h0);
      bus.cur_st = ST_INITIAL;
      #1;
      chk("rst_nxt", {29'b0, bus.nxt_st}, {29'b0, ST_INITIAL});
      @(negedge div_clk);
      rst = 1'b0;

      go_to(20);
      bus.cur_st = 3'd7;
      #1;
      chk("illegal_nxt", {29'b0, bus.nxt_st}, {29'b0, ST_INITIAL});
      cycle(1'b0);
      chk("illegal_clear", st_lamps(), {13'b0, ST_INITIAL, 16'h0000});

      go_to(18);
      chk("kick5_pre", st_lamps(), {13'b0, ST_UP_10, 16'h003F});
      cycle(1'b1);
      chk("kick5", st_lamps(), {13'b0, ST_DN_0, 16'h001F});
      cycle(1'b0);
      chk("kick5_fall", st_lamps(), {13'b0, ST_DN_0, 16'h000F});

      go_to(23);
      cycle(1'b1);
      chk("kick10_up10", st_lamps(), {13'b0, ST_DN_0, 16'h03FF});

      go_to(30);
      cycle(1'b1);
      chk("up15_flick_ignored", st_lamps(), {13'b0, ST_UP_15, 16'h007F});
      repeat (4) cycle(1'b0);
      chk("kick10_pre", st_lamps(), {13'b0, ST_UP_15, 16'h07FF});
      cycle(1'b1);
      chk("kick10", st_lamps(), {13'b0, ST_DN_5, 16'h03FF});
      repeat (5) cycle(1'b0);
      chk("kick10_bottom", st_lamps(), {13'b0, ST_DN_5, 16'h001F});
      cycle(1'b0);
      chk("kick10_rise", st_lamps(), {13'b0, ST_UP_15, 16'h003F});

      restart();
      for (int e = 1; e <= 70; e++) begin
         cycle(1'b1);
         if (e == 6)
            chk("held_up5_top", st_lamps(), {13'b0, ST_UP_5, 16'h003F});
         if (e == 19)
            chk("held_kick_a", st_lamps(), {13'b0, ST_DN_0, 16'h001F});
         if (e == 30)
            chk("held_top_b", st_lamps(), {13'b0, ST_UP_10, 16'h003F});
         if (e == 31)
            chk("held_kick_b", st_lamps(), {13'b0, ST_DN_0, 16'h001F});
         if (e >= 13)
            chk($sformatf("held_bound[%0d]", e),
                {31'b0, (bus.lamps <= 16'h003F) &&
                        (bus.cur_st == ST_DN_0 || bus.cur_st == ST_UP_10)},
                32'h1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
